// File: rtl/tlb_pkg.sv
// tlb_pkg: shared types and constants for the translation lookaside buffer.
//   - state_e      : controller states
//   - pte_bit_e    : bit positions of the V/R/W/X flags inside a PTE
//   - tlb_entry_t  : one TLB entry {valid, vpn, pte}
//   - make_paddr() : physical address from a leaf PTE and a virtual address
package tlb_pkg;

  localparam int PAGE_SHIFT = 12;
  localparam int PPN_LSB    = 10;
  localparam int PTE_WIDTH  = 64;
  localparam int VPN_W      = 36;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WALK_REQ,
    S_WALK_BUSY,
    S_WALK_WAIT,
    S_FILL
  } state_e;

  typedef enum int unsigned {
    PTE_V = 0,
    PTE_R = 1,
    PTE_W = 2,
    PTE_X = 3
  } pte_bit_e;

  typedef struct packed {
    logic                 valid;
    logic [VPN_W-1:0]     vpn;
    logic [PTE_WIDTH-1:0] pte;
  } tlb_entry_t;

  // PPN shifted up to the page boundary; bits pushed above bit 63 are dropped.
  function automatic logic [PTE_WIDTH-1:0] make_paddr(input logic [PTE_WIDTH-1:0] pte,
                                                      input logic [PTE_WIDTH-1:0] vaddr);
    return ((pte >> PPN_LSB) << PAGE_SHIFT) |
           (vaddr & ((64'd1 << PAGE_SHIFT) - 64'd1));
  endfunction

endpackage

// File: rtl/tlb_match.sv
// tlb_match: combinational tag compare over every TLB entry.
//   valid       : per-entry valid bits
//   tags        : per-entry VPN tags
//   vpn         : VPN being looked up
//   hit         : some valid entry holds vpn
//   hit_idx     : lowest-index matching entry
//   inv_idx     : lowest-index invalid entry
//   any_invalid : at least one entry is invalid
module tlb_match import tlb_pkg::*; #(
  parameter int ENTRIES   = 8,
  parameter int VPN_WIDTH = VPN_W,
  localparam int IDX_W    = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0]   valid,
  input  logic [VPN_WIDTH-1:0] tags [ENTRIES],
  input  logic [VPN_WIDTH-1:0] vpn,
  output logic                 hit,
  output logic [IDX_W-1:0]     hit_idx,
  output logic [IDX_W-1:0]     inv_idx,
  output logic                 any_invalid
);

  // NOTE: every output gets a default before the loop, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    hit         = 1'b0;
    hit_idx     = '0;
    inv_idx     = '0;
    any_invalid = 1'b0;
    // Scan downwards so the lowest matching / invalid index is the one kept.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && (tags[i] == vpn)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!valid[i]) begin
        any_invalid = 1'b1;
        inv_idx     = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/tlb.sv
// tlb: fully-associative TLB in front of the page-table walker.
//   req_valid/req_vaddr/req_ready : lookup request handshake
//   flush                         : invalidate every entry
//   resp_valid/paddr/perm/fault   : one-cycle registered response
//   walk_enable/walk_vaddr        : walk launch pulse and held address
//   walk_ready/walk_pte_array     : walker completion and its 8-PTE line
module tlb import tlb_pkg::*; #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int TLB_ENTRIES    = 8,
  parameter int VPN_WIDTH      = 36
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  input  logic [BUS_DATA_WIDTH-1:0]   req_vaddr,
  output logic                        req_ready,
  input  logic                        flush,
  output logic                        resp_valid,
  output logic [BUS_DATA_WIDTH-1:0]   resp_paddr,
  output logic [7:0]                  resp_perm,
  output logic                        resp_fault,
  output logic                        walk_enable,
  output logic [BUS_DATA_WIDTH-1:0]   walk_vaddr,
  input  logic                        walk_ready,
  input  logic [8*BUS_DATA_WIDTH-1:0] walk_pte_array
);

  localparam int IDX_W      = $clog2(TLB_ENTRIES);
  localparam int LINE_PTES  = 8;

  state_e                    state;
  tlb_entry_t                entries [TLB_ENTRIES];
  logic [IDX_W-1:0]          rr_ptr;
  logic                      flush_pending;
  logic [BUS_DATA_WIDTH-1:0] vaddr_q;
  logic [BUS_DATA_WIDTH-1:0] fill_pte;

  logic [TLB_ENTRIES-1:0]    valid_vec;
  logic [VPN_WIDTH-1:0]      tag_vec [TLB_ENTRIES];
  logic [VPN_WIDTH-1:0]      lookup_vpn;
  logic                      hit;
  logic [IDX_W-1:0]          hit_idx;
  logic [IDX_W-1:0]          inv_idx;
  logic                      any_invalid;

  logic [BUS_DATA_WIDTH-1:0] line_pte [LINE_PTES];
  logic [BUS_DATA_WIDTH-1:0] walk_pte;
  logic [BUS_DATA_WIDTH-1:0] hit_pte;
  logic                      flush_now;

  assign lookup_vpn = vaddr_q[PAGE_SHIFT +: VPN_WIDTH];
  assign walk_pte   = line_pte[vaddr_q[PAGE_SHIFT +: 3]];
  assign hit_pte    = entries[hit_idx].pte;
  // A flush arriving in the same cycle as the exit counts as pending.
  assign flush_now  = flush | flush_pending;

  always_comb begin
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      valid_vec[i] = entries[i].valid;
      tag_vec[i]   = entries[i].vpn;
    end
    for (int k = 0; k < LINE_PTES; k++) begin
      line_pte[k] = walk_pte_array[k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
    end
  end

  tlb_match #(
    .ENTRIES   (TLB_ENTRIES),
    .VPN_WIDTH (VPN_WIDTH)
  ) u_match (
    .valid       (valid_vec),
    .tags        (tag_vec),
    .vpn         (lookup_vpn),
    .hit         (hit),
    .hit_idx     (hit_idx),
    .inv_idx     (inv_idx),
    .any_invalid (any_invalid)
  );

  // NOTE: non-blocking assignments only, so every register in this block
  // updates from the values present before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      flush_pending <= 1'b0;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_fault    <= 1'b0;
      resp_paddr    <= '0;
      resp_perm     <= '0;
      walk_enable   <= 1'b0;
      walk_vaddr    <= '0;
      vaddr_q       <= '0;
      fill_pte      <= '0;
      // NOTE: only the valid bits need reset; tag and PTE are ignored while
      // an entry is invalid, so the storage itself stays un-reset.
      for (int i = 0; i < TLB_ENTRIES; i++) entries[i].valid <= 1'b0;
    end else begin
      resp_valid  <= 1'b0;
      walk_enable <= 1'b0;
      if (flush && (state != S_IDLE)) flush_pending <= 1'b1;

      unique case (state)
        S_IDLE: begin
          // Flush clears on this edge, so a request accepted alongside it
          // is looked up against an empty TLB.
          if (flush) begin
            for (int i = 0; i < TLB_ENTRIES; i++) entries[i].valid <= 1'b0;
          end
          if (req_valid) begin
            vaddr_q   <= req_vaddr;
            req_ready <= 1'b0;
            state     <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (hit) begin
            resp_valid <= 1'b1;
            resp_paddr <= make_paddr(hit_pte, vaddr_q);
            resp_perm  <= hit_pte[7:0];
            resp_fault <= ~hit_pte[PTE_V];
            if (flush_now) begin
              for (int i = 0; i < TLB_ENTRIES; i++) entries[i].valid <= 1'b0;
            end
            flush_pending <= 1'b0;
            req_ready     <= 1'b1;
            state         <= S_IDLE;
          end else begin
            walk_vaddr  <= vaddr_q;
            walk_enable <= 1'b1;
            state       <= S_WALK_REQ;
          end
        end

        S_WALK_REQ: state <= S_WALK_BUSY;

        // The walker's ready from a previous walk lingers until it restarts.
        S_WALK_BUSY: if (!walk_ready) state <= S_WALK_WAIT;

        S_WALK_WAIT: begin
          if (walk_ready) begin
            fill_pte   <= walk_pte;
            resp_valid <= 1'b1;
            resp_paddr <= make_paddr(walk_pte, vaddr_q);
            resp_perm  <= walk_pte[7:0];
            resp_fault <= ~walk_pte[PTE_V];
            state      <= S_FILL;
          end
        end

        S_FILL: begin
          if (flush_now) begin
            for (int i = 0; i < TLB_ENTRIES; i++) entries[i].valid <= 1'b0;
          end else if (fill_pte[PTE_V]) begin
            if (any_invalid) begin
              entries[inv_idx] <= '{valid: 1'b1, vpn: lookup_vpn, pte: fill_pte};
            end else begin
              entries[rr_ptr] <= '{valid: 1'b1, vpn: lookup_vpn, pte: fill_pte};
              rr_ptr          <= rr_ptr + 1'b1;
            end
          end
          flush_pending <= 1'b0;
          req_ready     <= 1'b1;
          state         <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb.sv
// tb_tlb: randomized self-checking bench for tlb. A behavioural TLB model
// (arrays of valid/vpn/pte plus a replacement pointer) predicts hit or miss
// and the response for every lookup; the bench also plays the walker.
module tb_tlb;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic [63:0]  req_vaddr;
  logic         req_ready;
  logic         flush;
  logic         resp_valid;
  logic [63:0]  resp_paddr;
  logic [7:0]   resp_perm;
  logic         resp_fault;
  logic         walk_enable;
  logic [63:0]  walk_vaddr;
  logic         walk_ready;
  logic [511:0] walk_pte_array;

  int n_pass  = 0;
  int n_total = 0;

  bit          m_valid [8];
  logic [35:0] m_vpn   [8];
  logic [63:0] m_pte   [8];
  int          m_rr;

  tlb dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_vaddr      (req_vaddr),
    .req_ready      (req_ready),
    .flush          (flush),
    .resp_valid     (resp_valid),
    .resp_paddr     (resp_paddr),
    .resp_perm      (resp_perm),
    .resp_fault     (resp_fault),
    .walk_enable    (walk_enable),
    .walk_vaddr     (walk_vaddr),
    .walk_ready     (walk_ready),
    .walk_pte_array (walk_pte_array)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void model_flush();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
  endfunction

  function automatic int model_find(input logic [35:0] vpn);
    for (int i = 0; i < 8; i++) if (m_valid[i] && m_vpn[i] == vpn) return i;
    return -1;
  endfunction

  function automatic void model_install(input logic [35:0] vpn, input logic [63:0] pte);
    int v = -1;
    for (int i = 0; i < 8; i++) if (!m_valid[i]) begin v = i; break; end
    if (v < 0) begin
      v    = m_rr;
      m_rr = (m_rr + 1) % 8;
    end
    m_valid[v] = 1'b1;
    m_vpn[v]   = vpn;
    m_pte[v]   = pte;
  endfunction

  function automatic logic [511:0] rand_line(input bit all_valid);
    logic [511:0] l;
    for (int k = 0; k < 8; k++) begin
      l[k*64 +: 64] = {$urandom, $urandom};
      l[k*64]       = all_valid ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
    return l;
  endfunction

  function automatic logic [63:0] mk_va(input logic [35:0] vpn, input logic [11:0] off);
    return {16'($urandom), vpn, off};
  endfunction

  // One lookup: request, then either expect a hit response or service the
  // walk. mode 0 = plain, 1 = flush with accept, 2 = flush during WALK_WAIT.
  task automatic lookup(input logic [63:0] va, input logic [511:0] line, input int mode);
    int          idx, sel, pulses;
    bit          exp_miss, saw_we, early, flushed;
    logic [63:0] exp_pte, exp_pa, prev_wva;
    pulses = 0; early = 1'b0; flushed = 1'b0;
    @(negedge clk);
    n_total++;
    if (req_ready !== 1'b1) $display("FAIL req_ready_idle: got %b expected 1", req_ready);
    else n_pass++;
    prev_wva = walk_vaddr;
    if (mode == 1) begin
      flush = 1'b1;
      model_flush();
    end
    req_valid = 1'b1;
    req_vaddr = va;
    idx       = model_find(va[47:12]);
    exp_miss  = (idx < 0);
    sel       = int'(va[14:12]);
    if (exp_miss) exp_pte = line[sel*64 +: 64];
    else          exp_pte = m_pte[idx];
    exp_pa = ((exp_pte >> 10) << 12) | (va & 64'hFFF);

    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
    saw_we = walk_enable;
    n_total++;
    if (saw_we !== exp_miss) $display("FAIL walk_on_miss va=%h: got %b expected %b", va, saw_we, exp_miss);
    else n_pass++;

    if (!saw_we) begin
      if (!exp_miss) begin
        n_total++;
        if (resp_valid !== 1'b1) $display("FAIL hit_latency: resp_valid got %b expected 1", resp_valid);
        else n_pass++;
        n_total++;
        if (resp_paddr !== exp_pa) $display("FAIL hit_paddr: got %h expected %h", resp_paddr, exp_pa);
        else n_pass++;
        n_total++;
        if (resp_perm !== exp_pte[7:0] || resp_fault !== ~exp_pte[0])
          $display("FAIL hit_perm_fault: got %h/%b expected %h/%b", resp_perm, resp_fault, exp_pte[7:0], ~exp_pte[0]);
        else n_pass++;
        n_total++;
        if (walk_vaddr !== prev_wva) $display("FAIL walk_vaddr_on_hit: got %h expected %h", walk_vaddr, prev_wva);
        else n_pass++;
      end
    end else begin
      n_total++;
      if (walk_vaddr !== va) $display("FAIL walk_vaddr: got %h expected %h", walk_vaddr, va);
      else n_pass++;
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk); pulses += walk_enable; early |= resp_valid;
      end
      walk_ready = 1'b0;
      repeat (2) begin
        @(negedge clk); pulses += walk_enable; early |= resp_valid;
      end
      if (mode == 2) begin
        flush   = 1'b1;
        flushed = 1'b1;
        model_flush();
        @(negedge clk); pulses += walk_enable; early |= resp_valid;
        flush = 1'b0;
      end
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk); pulses += walk_enable; early |= resp_valid;
      end
      walk_pte_array = line;
      walk_ready     = 1'b1;
      @(negedge clk);
      n_total++;
      if (resp_valid !== 1'b1) $display("FAIL miss_latency: resp_valid got %b expected 1", resp_valid);
      else n_pass++;
      n_total++;
      if (pulses != 0 || early) $display("FAIL walk_single_pulse: extra pulses %0d early resp %b expected 0/0", pulses, early);
      else n_pass++;
      n_total++;
      if (walk_vaddr !== va) $display("FAIL walk_vaddr_hold: got %h expected %h", walk_vaddr, va);
      else n_pass++;
      if (exp_miss) begin
        n_total++;
        if (resp_paddr !== exp_pa) $display("FAIL miss_paddr: got %h expected %h", resp_paddr, exp_pa);
        else n_pass++;
        n_total++;
        if (resp_perm !== exp_pte[7:0] || resp_fault !== ~exp_pte[0])
          $display("FAIL miss_perm_fault: got %h/%b expected %h/%b", resp_perm, resp_fault, exp_pte[7:0], ~exp_pte[0]);
        else n_pass++;
        if (exp_pte[0] && !flushed) model_install(va[47:12], exp_pte);
      end
    end
    for (int k = 0; k < 20 && req_ready !== 1'b1; k++) @(negedge clk);
    n_total++;
    if (req_ready !== 1'b1) $display("FAIL return_idle: req_ready got %b expected 1", req_ready);
    else n_pass++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_vaddr = '0; flush = 1'b0;
    walk_ready = 1'b0; walk_pte_array = '0;
    model_flush(); m_rr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({resp_valid, resp_fault, walk_enable} !== 3'b000)
      $display("FAIL reset_pulses: got %b expected 000", {resp_valid, resp_fault, walk_enable});
    else n_pass++;
    n_total++;
    if (resp_paddr !== 64'd0 || resp_perm !== 8'd0 || walk_vaddr !== 64'd0)
      $display("FAIL reset_data: got %h/%h/%h expected 0/0/0", resp_paddr, resp_perm, walk_vaddr);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_total++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", req_ready);
    else n_pass++;
  endtask

  task automatic test_cold_miss_and_hit();
    logic [511:0] line = rand_line(1'b0);
    line[3*64 +: 64] = 64'h0000_0000_0080_0401;
    lookup(64'h0000_0040_2000_3123, line, 0);
    // PPN = 0x800401 >> 10 = 0x2001; paddr = (0x2001 << 12) | 0x123.
    n_total++;
    if (resp_paddr !== 64'h0000_0000_0200_1123 || resp_perm !== 8'h01)
      $display("FAIL cold_miss_const: got %h/%h expected 0000000002001123/01", resp_paddr, resp_perm);
    else n_pass++;
    lookup(64'h0000_0040_2000_3456, rand_line(1'b0), 0);
    n_total++;
    if (resp_paddr !== 64'h0000_0000_0200_1456) $display("FAIL hit_const: got %h expected 0000000002001456", resp_paddr);
    else n_pass++;
  endtask

  task automatic test_fault();
    logic [63:0]  va   = mk_va(36'h1_2345_6785, 12'h0AB);
    logic [511:0] line = rand_line(1'b1);
    line[5*64] = 1'b0;
    lookup(va, line, 0);
    n_total++;
    if (resp_fault !== 1'b1) $display("FAIL fault_flag: got %b expected 1", resp_fault);
    else n_pass++;
    lookup(va, rand_line(1'b1), 0);   // model predicts a second walk
  endtask

  task automatic test_eviction();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    model_flush();
    for (int i = 0; i < 9; i++) lookup(mk_va(36'h0_0A00_0000 + 36'(i), 12'(i)), rand_line(1'b1), 0);
    lookup(mk_va(36'h0_0A00_0008, 12'h111), rand_line(1'b1), 0);  // in entry 0: hit
    lookup(mk_va(36'h0_0A00_0000, 12'h222), rand_line(1'b1), 0);  // evicted: miss
    lookup(mk_va(36'h0_0A00_0002, 12'h333), rand_line(1'b1), 0);  // still cached
    lookup(mk_va(36'h0_0A00_0001, 12'h444), rand_line(1'b1), 0);  // evicted by refill
  endtask

  task automatic test_flush();
    logic [63:0] va_a = mk_va(36'h7_7000_0001, 12'h010);
    logic [63:0] va_b = mk_va(36'h7_7000_0002, 12'h020);
    lookup(va_a, rand_line(1'b1), 0);
    lookup(va_b, rand_line(1'b1), 2);   // response still delivered
    lookup(va_b, rand_line(1'b1), 0);
    lookup(va_a, rand_line(1'b1), 0);
    lookup(va_a, rand_line(1'b1), 1);   // flush with accept: misses
  endtask

  task automatic test_reset_mid_walk();
    logic [63:0] va_c = mk_va(36'h3_3000_0003, 12'h030);
    lookup(va_c, rand_line(1'b1), 0);
    @(negedge clk);
    req_valid = 1'b1; req_vaddr = mk_va(36'h3_3000_0004, 12'h040);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (walk_enable !== 1'b1) $display("FAIL rst_walk_start: got %b expected 1", walk_enable);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_total++;
    if ({req_ready, resp_valid, walk_enable} !== 3'b100)
      $display("FAIL rst_mid_walk: got %b expected 100", {req_ready, resp_valid, walk_enable});
    else n_pass++;
    reset = 1'b0; walk_ready = 1'b0;
    model_flush(); m_rr = 0;
    lookup(va_c, rand_line(1'b1), 0);
  endtask

  task automatic test_random();
    int mode;
    for (int n = 0; n < 40; n++) begin
      mode = ($urandom_range(0, 9) == 0) ? 1 : (($urandom_range(0, 9) == 0) ? 2 : 0);
      lookup(mk_va(36'h0_5000_0000 + 36'($urandom_range(0, 11) * 37), 12'($urandom)),
             rand_line(1'b0), mode);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss_and_hit();
    test_fault();
    test_eviction();
    test_flush();
    test_reset_mid_walk();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
